// File: rtl/hps_reset_pkg.sv
// rtl/hps_reset_pkg.sv - shared types and constants for the HPS reset sequencer
package hps_reset_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT_ASSERT,
        WAIT_RELEASE,
        COOLDOWN
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_COLD  = 2'd1;
    localparam logic [1:0] CAUSE_WARM  = 2'd2;
    localparam logic [1:0] CAUSE_DEBUG = 2'd3;

    // Width of the shared down-counter: wide enough for the largest value it is ever loaded with.
    function automatic int cnt_width(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hps_rst_sync.sv
// rtl/hps_rst_sync.sv - two-flop synchroniser resetting to 1
module hps_rst_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous level; idles high so a reset looks like "HPS released".
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/hps_reset_sequencer.sv
// rtl/hps_reset_sequencer.sv - cold/warm/debug HPS reset arbiter and pulse stretcher; optional HPS_RST_CNT_EN grant counters
module hps_reset_sequencer
    import hps_reset_pkg::*;
#(
    parameter int COLD_LEN    = 6,
    parameter int WARM_LEN    = 2,
    parameter int DEBUG_LEN   = 32,
    parameter int ACK_TIMEOUT = 65535,
    parameter int COOLDOWN    = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_cold,
    input  logic             req_warm,
    input  logic             req_debug,
    input  logic             h2f_reset_n,
    input  logic             clear_err,
    output logic             cold_req_n,
    output logic             warm_req_n,
    output logic             debug_req_n,
    output logic             busy,
    output logic [1:0]       active_cause,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cold_cnt,
    output logic [CNT_W-1:0] warm_cnt,
    output logic [CNT_W-1:0] debug_cnt
);

    localparam int CW = cnt_width(COLD_LEN - 1, WARM_LEN - 1, DEBUG_LEN - 1, ACK_TIMEOUT, COOLDOWN - 1);

    localparam logic [CW-1:0] LD_COLD  = CW'(COLD_LEN - 1);
    localparam logic [CW-1:0] LD_WARM  = CW'(WARM_LEN - 1);
    localparam logic [CW-1:0] LD_DEBUG = CW'(DEBUG_LEN - 1);
    localparam logic [CW-1:0] LD_ACK   = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] LD_COOL  = CW'(COOLDOWN - 1);

    // Bit order for request vectors: [0] cold, [1] warm, [2] debug.
    logic [2:0]    w_req;
    logic [2:0]    w_event;
    logic [2:0]    r_req_q;
    logic [2:0]    r_pending;
    logic [2:0]    w_pend_clr;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_cause;
    logic [1:0]    w_cause_nxt;
    logic [2:0]    r_req_n;
    logic [2:0]    w_req_n_nxt;
    logic          r_busy;
    logic          r_err;
    logic          w_timeout;
    logic          w_h2f_sync;

    hps_rst_sync u_h2f_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (h2f_reset_n),
        .o_sync  (w_h2f_sync)
    );

    assign w_req   = {req_debug, req_warm, req_cold};
    assign w_event = w_req & ~r_req_q;

    // Rising-edge history and pending requests; a new event beats a same-cycle grant clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q   <= 3'b111;
            r_pending <= 3'b000;
        end else begin
            r_req_q   <= w_req;
            r_pending <= (r_pending & ~w_pend_clr) | w_event;
        end
    end

    // Next-state, shared counter and registered-output values for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cause_nxt = r_cause;
        w_req_n_nxt = 3'b111;
        w_pend_clr  = 3'b000;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cause_nxt = CAUSE_NONE;
                if (r_pending[0]) begin
                    // Cold supersedes everything queued behind it.
                    w_pend_clr  = 3'b111;
                    w_cause_nxt = CAUSE_COLD;
                    w_cnt_nxt   = LD_COLD;
                    w_req_n_nxt = 3'b110;
                    w_state_nxt = PULSE;
                end else if (r_pending[1]) begin
                    w_pend_clr  = 3'b010;
                    w_cause_nxt = CAUSE_WARM;
                    w_cnt_nxt   = LD_WARM;
                    w_req_n_nxt = 3'b101;
                    w_state_nxt = PULSE;
                end else if (r_pending[2]) begin
                    w_pend_clr  = 3'b100;
                    w_cause_nxt = CAUSE_DEBUG;
                    w_cnt_nxt   = LD_DEBUG;
                    w_req_n_nxt = 3'b011;
                    w_state_nxt = PULSE;
                end
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    if (r_cause == CAUSE_DEBUG) begin
                        w_state_nxt = hps_reset_pkg::COOLDOWN;
                        w_cnt_nxt   = LD_COOL;
                    end else begin
                        w_state_nxt = WAIT_ASSERT;
                        w_cnt_nxt   = LD_ACK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    case (r_cause)
                        CAUSE_COLD:  w_req_n_nxt = 3'b110;
                        CAUSE_WARM:  w_req_n_nxt = 3'b101;
                        CAUSE_DEBUG: w_req_n_nxt = 3'b011;
                        default:     w_req_n_nxt = 3'b111;
                    endcase
                end
            end
            WAIT_ASSERT: begin
                if (!w_h2f_sync) begin
                    w_state_nxt = WAIT_RELEASE;
                    w_cnt_nxt   = LD_ACK;
                end else if (r_cnt == '0) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = hps_reset_pkg::COOLDOWN;
                    w_cnt_nxt   = LD_COOL;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (w_h2f_sync) begin
                    w_state_nxt = hps_reset_pkg::COOLDOWN;
                    w_cnt_nxt   = LD_COOL;
                end else if (r_cnt == '0) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = hps_reset_pkg::COOLDOWN;
                    w_cnt_nxt   = LD_COOL;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            hps_reset_pkg::COOLDOWN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_cause_nxt = CAUSE_NONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cause_nxt = CAUSE_NONE;
            end
        endcase
    end

    // State register plus the registered pulse, busy and cause outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cause <= CAUSE_NONE;
            r_req_n <= 3'b111;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cause <= w_cause_nxt;
            r_req_n <= w_req_n_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Sticky handshake-timeout flag; a fresh timeout beats a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (clear_err) begin
            r_err <= 1'b0;
        end
    end

    assign cold_req_n   = r_req_n[0];
    assign warm_req_n   = r_req_n[1];
    assign debug_req_n  = r_req_n[2];
    assign busy         = r_busy;
    assign active_cause = r_cause;
    assign timeout_err  = r_err;

`ifdef HPS_RST_CNT_EN
    logic [CNT_W-1:0] r_cold_cnt;
    logic [CNT_W-1:0] r_warm_cnt;
    logic [CNT_W-1:0] r_debug_cnt;
    logic             w_grant;

    assign w_grant = (r_state == IDLE) && (w_state_nxt == PULSE);

    // Saturating per-cause grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cold_cnt  <= '0;
            r_warm_cnt  <= '0;
            r_debug_cnt <= '0;
        end else if (w_grant) begin
            if (w_cause_nxt == CAUSE_COLD && r_cold_cnt != '1) begin
                r_cold_cnt <= r_cold_cnt + 1'b1;
            end
            if (w_cause_nxt == CAUSE_WARM && r_warm_cnt != '1) begin
                r_warm_cnt <= r_warm_cnt + 1'b1;
            end
            if (w_cause_nxt == CAUSE_DEBUG && r_debug_cnt != '1) begin
                r_debug_cnt <= r_debug_cnt + 1'b1;
            end
        end
    end

    assign cold_cnt  = r_cold_cnt;
    assign warm_cnt  = r_warm_cnt;
    assign debug_cnt = r_debug_cnt;
`else
    assign cold_cnt  = '0;
    assign warm_cnt  = '0;
    assign debug_cnt = '0;
`endif

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// tb/tb_hps_reset_sequencer.sv - scoreboard bench for hps_reset_sequencer
module tb_hps_reset_sequencer;

    localparam int COLD_LEN  = 6;
    localparam int WARM_LEN  = 2;
    localparam int DEBUG_LEN = 32;
    localparam int ACK_TO    = 100;
    localparam int COOL      = 16;
    localparam int CNT_W     = 2;
    localparam int SYNC      = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_cold = 1'b0;
    logic             req_warm = 1'b0;
    logic             req_debug = 1'b0;
    logic             h2f_reset_n = 1'b1;
    logic             clear_err = 1'b0;
    logic             cold_req_n;
    logic             warm_req_n;
    logic             debug_req_n;
    logic             busy;
    logic [1:0]       active_cause;
    logic             timeout_err;
    logic [CNT_W-1:0] cold_cnt;
    logic [CNT_W-1:0] warm_cnt;
    logic [CNT_W-1:0] debug_cnt;

    hps_reset_sequencer #(
        .COLD_LEN    (COLD_LEN),
        .WARM_LEN    (WARM_LEN),
        .DEBUG_LEN   (DEBUG_LEN),
        .ACK_TIMEOUT (ACK_TO),
        .COOLDOWN    (COOL),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_cold     (req_cold),
        .req_warm     (req_warm),
        .req_debug    (req_debug),
        .h2f_reset_n  (h2f_reset_n),
        .clear_err    (clear_err),
        .cold_req_n   (cold_req_n),
        .warm_req_n   (warm_req_n),
        .debug_req_n  (debug_req_n),
        .busy         (busy),
        .active_cause (active_cause),
        .timeout_err  (timeout_err),
        .cold_cnt     (cold_cnt),
        .warm_cnt     (warm_cnt),
        .debug_cnt    (debug_cnt)
    );

    always #10 clk = ~clk;

    // Posedge count; read at negedges, so a value k means "after edge k".
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int cause;
        int start;
        int len;
    } pulse_t;

    pulse_t sb_q[$];

    task automatic expect_pulse(input int cause, input int start, input int len);
        pulse_t e;
        e.cause = cause;
        e.start = start;
        e.len   = len;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input int cause, input int start, input int len);
        pulse_t e;
        if (sb_q.size() == 0) begin
            chk("sb_unexpected_pulse_cause", cause, 0);
        end else begin
            e = sb_q.pop_front();
            chk("sb_cause", cause, e.cause);
            chk("sb_start", start, e.start);
            chk("sb_len", len, e.len);
        end
    endtask

    // Pulse monitor: measures every low pulse on the three request outputs.
    wire [2:0] mon_now = {debug_req_n, warm_req_n, cold_req_n};
    logic [2:0] mon_prev = 3'b111;
    int mon_start [3];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mon_prev[i] && !mon_now[i]) mon_start[i] <= cyc;
            if (!mon_prev[i] && mon_now[i]) sb_check(i + 1, mon_start[i], cyc - mon_start[i]);
        end
        mon_prev <= mon_now;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget, output int fall);
        fall = -1;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                fall = cyc;
                break;
            end
            tick(1);
        end
        if (fall < 0) chk(tag, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k0;
        int r;
        int fall;
        int exp_cold;
        int exp_warm;
        int exp_dbg;

        tick(3);
        chk("rst_cold_n", cold_req_n, 1);
        chk("rst_warm_n", warm_req_n, 1);
        chk("rst_debug_n", debug_req_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cause", active_cause, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_cnts", {cold_cnt, warm_cnt, debug_cnt}, 0);
        rst = 1'b0;
        tick(2);

        // 1: warm request with a normal HPS handshake
        k0 = cyc;
        req_warm = 1'b1;
        expect_pulse(2, k0 + 2, WARM_LEN);
        tick(1);
        req_warm = 1'b0;
        tick(4);
        chk("t1_busy", busy, 1);
        chk("t1_cause", active_cause, 2);
        h2f_reset_n = 1'b0;
        tick(20);
        h2f_reset_n = 1'b1;
        r = cyc;
        wait_idle("t1_idle_timeout_busy", 80, fall);
        chk("t1_busy_fall", fall, r + SYNC + 1 + COOL);
        chk("t1_cause_idle", active_cause, 0);
        chk("t1_err", timeout_err, 0);

        // 2: cold and debug together; cold wins, debug is dropped
        k0 = cyc;
        req_cold  = 1'b1;
        req_debug = 1'b1;
        expect_pulse(1, k0 + 2, COLD_LEN);
        tick(1);
        req_cold  = 1'b0;
        req_debug = 1'b0;
        tick(8);
        h2f_reset_n = 1'b0;
        tick(10);
        h2f_reset_n = 1'b1;
        wait_idle("t2_idle_timeout_busy", 80, fall);
        tick(60);
        chk("t2_no_debug_busy", busy, 0);

        // 3: cold arriving during warm cooldown
        k0 = cyc;
        req_warm = 1'b1;
        expect_pulse(2, k0 + 2, WARM_LEN);
        tick(1);
        req_warm = 1'b0;
        tick(4);
        h2f_reset_n = 1'b0;
        tick(10);
        h2f_reset_n = 1'b1;
        r = cyc;
        tick(5);
        req_cold = 1'b1;
        expect_pulse(1, r + SYNC + 1 + COOL + 1, COLD_LEN);
        tick(1);
        req_cold = 1'b0;
        tick(12);
        chk("t3_cause_cooldown", active_cause, 2);
        tick(1);
        chk("t3_cause_idle", active_cause, 0);
        chk("t3_busy_idle", busy, 0);
        tick(1);
        chk("t3_cause_cold", active_cause, 1);
        chk("t3_cold_n", cold_req_n, 0);
        tick(8);
        h2f_reset_n = 1'b0;
        tick(5);
        h2f_reset_n = 1'b1;
        wait_idle("t3_idle_timeout_busy", 80, fall);

        // 4: warm with h2f_reset_n stuck high -> timeout
        k0 = cyc;
        req_warm = 1'b1;
        expect_pulse(2, k0 + 2, WARM_LEN);
        tick(1);
        req_warm = 1'b0;
        tick(102);
        chk("t4_err_before", timeout_err, 0);
        chk("t4_busy_wait", busy, 1);
        tick(1);
        chk("t4_err_set", timeout_err, 1);
        wait_idle("t4_idle_timeout_busy", 80, fall);
        chk("t4_busy_fall", fall, k0 + 2 + WARM_LEN + ACK_TO + COOL);
        chk("t4_err_sticky", timeout_err, 1);
`ifdef HPS_RST_CNT_EN
        exp_cold = 2;
        exp_warm = 3;
`else
        exp_cold = 0;
        exp_warm = 0;
`endif
        chk("t4_cold_cnt", cold_cnt, exp_cold);
        chk("t4_warm_cnt", warm_cnt, exp_warm);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        chk("t4_err_cleared", timeout_err, 0);

        // 5: reset in the 3rd cycle of a debug pulse, request held high
        k0 = cyc;
        req_debug = 1'b1;
        expect_pulse(3, k0 + 2, 3);
        tick(4);
        chk("t5_debug_low", debug_req_n, 0);
        rst = 1'b1;
        tick(1);
        chk("t5_debug_released", debug_req_n, 1);
        chk("t5_busy_rst", busy, 0);
        tick(2);
        rst = 1'b0;
        tick(80);
        chk("t5_no_retrigger", busy, 0);
        chk("t5_cause", active_cause, 0);
        chk("t5_cnts", {cold_cnt, warm_cnt, debug_cnt}, 0);
        req_debug = 1'b0;
        tick(2);

        // 6: five debug grants against a 2-bit counter
        for (int n = 1; n <= 5; n++) begin
            k0 = cyc;
            req_debug = 1'b1;
            expect_pulse(3, k0 + 2, DEBUG_LEN);
            tick(1);
            req_debug = 1'b0;
            tick(2);
`ifdef HPS_RST_CNT_EN
            exp_dbg = (n > 3) ? 3 : n;
`else
            exp_dbg = 0;
`endif
            chk($sformatf("t6_debug_cnt_%0d", n), debug_cnt, exp_dbg);
            wait_idle("t6_idle_timeout_busy", 120, fall);
        end

        tick(5);
        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
